// File: rtl/cache_defs.sv
// Shared definitions for the cache line refill engine, its controller and benches.
package cache_defs;
  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_BITS = $clog2(LINE_WORDS);
  localparam int ADDR_WIDTH  = 12;
  localparam int DATA_WIDTH  = 32;
  localparam int LINE_ADDR_W = ADDR_WIDTH - OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;
endpackage

// File: rtl/cache_line_refill.sv
// Moves a dirty victim line to BRAM and/or fetches a fill line, one word per cycle
// through the single BRAM port, then pulses done with the fetched line held.
module cache_line_refill
  import cache_defs::*;
#(
  parameter int LINE_WORDS = cache_defs::LINE_WORDS,
  parameter int ADDR_WIDTH = cache_defs::ADDR_WIDTH,
  parameter int DATA_WIDTH = cache_defs::DATA_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic                                      req_evict,
  input  logic                                      req_fill,
  input  logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0]  victim_line_addr,
  input  logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0]  fill_line_addr,
  input  logic [DATA_WIDTH*LINE_WORDS-1:0]          victim_data,
  output logic [DATA_WIDTH*LINE_WORDS-1:0]          fill_data,
  output logic                                      done,
  output logic [ADDR_WIDTH-1:0]                     mem_addr,
  output logic [DATA_WIDTH-1:0]                     mem_wdata,
  output logic                                      mem_we,
  output logic                                      mem_re,
  input  logic [DATA_WIDTH-1:0]                     mem_rdata
);
  localparam int OB  = $clog2(LINE_WORDS);
  localparam int LAW = ADDR_WIDTH - OB;
  localparam logic [OB:0] CNT_END     = (OB+1)'(LINE_WORDS);
  localparam logic [OB:0] CNT_WB_LAST = (OB+1)'(LINE_WORDS - 1);

  refill_state_e                         state_q, state_d;
  logic [OB:0]                           cnt_q, cnt_d;
  logic [LAW-1:0]                        victim_line_q, victim_line_d;
  logic [LAW-1:0]                        fill_line_q, fill_line_d;
  logic                                  fill_req_q, fill_req_d;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] victim_q, victim_d;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] fill_q, fill_d;
  logic                                  done_q, done_d;
  logic                                  mem_we_q, mem_we_d;
  logic                                  mem_re_q, mem_re_d;
  logic [ADDR_WIDTH-1:0]                 mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]                 mem_wdata_q, mem_wdata_d;
  logic [OB-1:0]                         cap_idx;
  logic                                  accept;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;
  // Read data returns one cycle late, so the word landing now was issued at cnt-1.
  assign cap_idx   = OB'(cnt_q - 1'b1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    victim_line_d = victim_line_q;
    fill_line_d   = fill_line_q;
    fill_req_d    = fill_req_q;
    victim_d      = victim_q;
    fill_d        = fill_q;
    done_d        = 1'b0;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          victim_line_d = victim_line_addr;
          fill_line_d   = fill_line_addr;
          fill_req_d    = req_fill;
          victim_d      = victim_data;
          cnt_d         = '0;
          if (req_evict)     state_d = ST_WB;
          else if (req_fill) state_d = ST_RD;
          else               state_d = ST_DONE;
        end
      end
      ST_WB: begin
        if (cnt_q == CNT_WB_LAST) begin
          cnt_d   = '0;
          state_d = fill_req_q ? ST_RD : ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RD: begin
        if (cnt_q != '0) fill_d[cap_idx] = mem_rdata;
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // BRAM-side outputs are registered, so they are derived from the next state.
    done_d = (state_d == ST_DONE);
    if (state_d == ST_WB) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = {victim_line_d, cnt_d[OB-1:0]};
      mem_wdata_d = victim_d[cnt_d[OB-1:0]];
    end else if (state_d == ST_RD && cnt_d < CNT_END) begin
      mem_re_d   = 1'b1;
      mem_addr_d = {fill_line_d, cnt_d[OB-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      victim_line_q <= '0;
      fill_line_q   <= '0;
      fill_req_q    <= 1'b0;
      victim_q      <= '0;
      fill_q        <= '0;
      done_q        <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      victim_line_q <= victim_line_d;
      fill_line_q   <= fill_line_d;
      fill_req_q    <= fill_req_d;
      victim_q      <= victim_d;
      fill_q        <= fill_d;
      done_q        <= done_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign fill_data = fill_q;
  assign done      = done_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_cache_line_refill.sv
// Directed bench: a per-cycle expectation queue built from the transfer rules
// is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_cache_line_refill;
  import cache_defs::*;
  localparam int LW  = 4;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LAW = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready, req_evict, req_fill;
  logic [LAW-1:0]  victim_line_addr, fill_line_addr;
  logic [LW*DW-1:0] victim_data, fill_data;
  logic            done;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            mem_we, mem_re;

  always #5 clk = ~clk;

  cache_line_refill #(.LINE_WORDS(LW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_evict(req_evict), .req_fill(req_fill),
    .victim_line_addr(victim_line_addr), .fill_line_addr(fill_line_addr),
    .victim_data(victim_data), .fill_data(fill_data), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // BRAM model with a preload port used only while the DUT is idle.
  logic [DW-1:0] bram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en)       bram[pl_addr]  <= pl_data;
    else if (mem_we) bram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= bram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic            rdy, we, re, done;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [LW*DW-1:0] fill;
  } exp_t;

  exp_t       expq[$];
  exp_t       ce;
  logic [LW*DW-1:0] mdl_fill;
  bit         chk_en;
  int         checks = 0, failures = 0;
  int         acc_cyc, done_cyc;

  task automatic chk(input string nm, input logic [LW*DW-1:0] got, input logic [LW*DW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e.rdy = 1'b1; e.we = 1'b0; e.re = 1'b0; e.done = 1'b0;
    e.addr = '0; e.wdata = '0; e.fill = mdl_fill;
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (expq.size() > 0) ce = expq.pop_front();
      else                 ce = idle_e();
      chk("req_ready", {127'd0, req_ready}, {127'd0, ce.rdy});
      chk("mem_we",    {127'd0, mem_we},    {127'd0, ce.we});
      chk("mem_re",    {127'd0, mem_re},    {127'd0, ce.re});
      chk("done",      {127'd0, done},      {127'd0, ce.done});
      if (ce.we || ce.re) chk("mem_addr", {116'd0, mem_addr}, {116'd0, ce.addr});
      if (ce.we)          chk("mem_wdata", {96'd0, mem_wdata}, {96'd0, ce.wdata});
      chk("fill_data", fill_data, ce.fill);
      if (done === 1'b1) done_cyc = cyc;
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Called at posedge+1: drives the request and queues the expected cycles 0..done.
  task automatic issue(input bit ev, input bit fl, input logic [LAW-1:0] vl,
                       input logic [LAW-1:0] fline, input logic [LW*DW-1:0] vd);
    exp_t e;
    logic [AW-1:0] a;
    req_valid = 1'b1; req_evict = ev; req_fill = fl;
    victim_line_addr = vl; fill_line_addr = fline; victim_data = vd;
    done_cyc = -1000;
    e = idle_e(); expq.push_back(e);
    if (ev) for (int k = 0; k < LW; k++) begin
      e = idle_e(); e.rdy = 1'b0; e.we = 1'b1;
      a = AW'(int'(vl) * LW + k);
      e.addr = a; e.wdata = vd[k*DW +: DW];
      ref_mem[a] = e.wdata;
      expq.push_back(e);
    end
    if (fl) for (int k = 0; k <= LW; k++) begin
      e = idle_e(); e.rdy = 1'b0; e.re = (k < LW);
      e.addr = AW'(int'(fline) * LW + k);
      expq.push_back(e);
      if (k >= 1) mdl_fill[(k-1)*DW +: DW] = ref_mem[AW'(int'(fline) * LW + k - 1)];
    end
    e = idle_e(); e.rdy = 1'b0; e.done = 1'b1; expq.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int want_cycle);
    int n = 0;
    while (expq.size() > 0 && n < 200) begin
      @(posedge clk); n++;
    end
    if (expq.size() > 0) begin
      chk("done_timeout", 128'd1, 128'd0);
      expq.delete();
    end
    #1;
    chk("done_cycle", LW*DW'(done_cyc - acc_cyc + 1), LW*DW'(want_cycle));
  endtask

  initial begin
    rst_n = 1'b0; chk_en = 1'b0; mdl_fill = '0;
    req_valid = 1'b1; req_evict = 1'b1; req_fill = 1'b1;
    victim_line_addr = '1; fill_line_addr = '1; victim_data = '1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int k = 0; k < LW; k++) begin
      preload(AW'(12'h010 + k), DW'(32'hA0 + k));
      preload(AW'(12'h014 + k), DW'(32'hB0 + k));
      preload(AW'(12'h018 + k), DW'(32'hC0 + k));
    end
    preload(12'h022, 32'h5EE0_0022);
    preload(12'h023, 32'h5EE0_0023);
    preload(12'h000, 32'h5EE0_0000);

    // Reset held with a pending request: reset values, ready high, no transfer.
    @(negedge clk);
    chk("rst_ready", {127'd0, req_ready}, 128'd1);
    chk("rst_done",  {127'd0, done},      128'd0);
    chk("rst_we",    {127'd0, mem_we},    128'd0);
    chk("rst_re",    {127'd0, mem_re},    128'd0);
    chk("rst_addr",  {116'd0, mem_addr},  128'd0);
    chk("rst_wdata", {96'd0, mem_wdata},  128'd0);
    chk("rst_fill",  fill_data,           128'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Fill only, line 0x04.
    issue(1'b0, 1'b1, 10'h000, 10'h004, '0);
    wait_done(6);
    chk("fill_only_lit", fill_data, 128'h000000A3_000000A2_000000A1_000000A0);

    // Evict + fill on the same line, issued back-to-back.
    issue(1'b1, 1'b1, 10'h004, 10'h004, 128'h00000044_00000033_00000022_00000011);
    wait_done(10);
    chk("same_line_lit", fill_data, 128'h00000044_00000033_00000022_00000011);

    // Evict only at the top line: no wrap into address 0, no reads.
    issue(1'b1, 1'b0, 10'h3FF, 10'h000, 128'h000000D3_000000D2_000000D1_000000D0);
    wait_done(5);
    chk("top_word_lit",  {96'd0, bram[12'hFFF]}, 128'h000000D3);
    chk("top_first_lit", {96'd0, bram[12'hFFC]}, 128'h000000D0);
    chk("no_wrap_lit",   {96'd0, bram[12'h000]}, 128'h5EE00000);
    chk("evict_fill_held", fill_data, 128'h00000044_00000033_00000022_00000011);

    // Fill line 0x05 with a stray request pulsed during RD.
    issue(1'b0, 1'b1, 10'h000, 10'h005, '0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_evict = 1'b1; req_fill = 1'b1;
    victim_line_addr = 10'h006; fill_line_addr = 10'h006;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done(6);
    chk("busy_lit", fill_data, 128'h000000B3_000000B2_000000B1_000000B0);

    // The held second request for line 0x06.
    issue(1'b0, 1'b1, 10'h000, 10'h006, '0);
    wait_done(6);
    chk("second_lit", fill_data, 128'h000000C3_000000C2_000000C1_000000C0);

    // No-op request.
    issue(1'b0, 1'b0, 10'h000, 10'h000, '0);
    wait_done(1);

    // Writeback aborted by reset during cycle 3.
    issue(1'b1, 1'b0, 10'h008, 10'h000, 128'h000000E3_000000E2_000000E1_000000E0);
    @(posedge clk);
    @(posedge clk); #1;
    chk_en = 1'b0; expq.delete();
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we",    {127'd0, mem_we},    128'd0);
    chk("abort_ready", {127'd0, req_ready}, 128'd1);
    chk("abort_fill",  fill_data,           128'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_mem[12'h022] = 32'h5EE0_0022;
    ref_mem[12'h023] = 32'h5EE0_0023;
    mdl_fill = '0;
    chk("abort_w0", {96'd0, bram[12'h020]}, 128'h000000E0);
    chk("abort_w1", {96'd0, bram[12'h021]}, 128'h000000E1);
    chk("abort_w2", {96'd0, bram[12'h022]}, 128'h5EE00022);
    chk("abort_w3", {96'd0, bram[12'h023]}, 128'h5EE00023);
    chk_en = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 10'h000, 10'h008, '0);
    wait_done(6);
    chk("abort_readback", fill_data, 128'h5EE00023_5EE00022_000000E1_000000E0);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_line_refill.md
# cache_line_refill

Line transfer engine between the data cache and the backing data BRAM. On a miss the cache hands it an optional dirty-victim line to write back and a line address to fill. It moves whole lines one 32-bit word per cycle through the BRAM's single port, then returns the filled line with a one-cycle `done` pulse. The cache holds `clk_stall` high from request until `done`.

## Interface
- `LINE_WORDS`, 4, words per cache line; power of two, ≥2.
- `ADDR_WIDTH`, 12, BRAM word-address width.
- `DATA_WIDTH`, 32, word width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  cache requests a transfer; held until accepted.
- `req_ready`  out  1  high only in IDLE; accept = `req_valid & req_ready`.
- `req_evict`  in  1  write `victim_data` back before any fill.
- `req_fill`  in  1  read the line at `fill_line_addr`.
- `victim_line_addr`  in  ADDR_WIDTH-log2(LINE_WORDS)  line address of the victim.
- `fill_line_addr`  in  ADDR_WIDTH-log2(LINE_WORDS)  line address to fetch.
- `victim_data`  in  DATA_WIDTH*LINE_WORDS  victim line; word 0 in the LSBs.
- `fill_data`  out  DATA_WIDTH*LINE_WORDS  fetched line; word 0 in the LSBs.
- `done`  out  1  one-cycle completion pulse.
- `mem_addr`  out  ADDR_WIDTH  BRAM word address.
- `mem_wdata`  out  DATA_WIDTH  BRAM write data.
- `mem_we`  out  1  BRAM write strobe, full word.
- `mem_re`  out  1  BRAM read strobe.
- `mem_rdata`  in  DATA_WIDTH  BRAM read data; valid the cycle after `mem_re`.

## Operation
- States: IDLE, WB, RD, DONE. A word counter `cnt` runs 0..LINE_WORDS.
- On accept, latch both line addresses, both flags and `victim_data`. Inputs are don't-care after accept.
- IDLE -> WB if `req_evict`; else -> RD if `req_fill`; else -> DONE.
- WB: one write per cycle. `mem_we`=1, `mem_addr`={victim_line, cnt}, `mem_wdata`=victim word `cnt`.
- After word LINE_WORDS-1, WB -> RD if fill is latched, else -> DONE.
- RD: with `cnt` < LINE_WORDS, drive `mem_re`=1 and `mem_addr`={fill_line, cnt}.
- RD: with `cnt` ≥ 1, capture `mem_rdata` into `fill_data` word `cnt`-1.
- RD -> DONE when `cnt`==LINE_WORDS.
- DONE: `done`=1 for one cycle, then -> IDLE.
- `fill_data` only changes during RD captures. It holds between requests, so it is stable from `done` until the next fill.
- Address formation is pure concatenation; there is no carry out of the offset field.
- Victim address equal to fill address is legal: the writeback completes first and the fill reads back the written data.
- `req_valid` while not in IDLE is ignored (`req_ready`=0).
- `mem_we` and `mem_re` are never high together.

## Timing
- Reset values: state IDLE, `cnt`=0, `fill_data`=0, `done`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0. `req_ready`=1 while in reset.
- Asserting `rst_n` mid-transfer aborts at once. Strobes drop asynchronously. Words already written stay written, and a partial `fill_data` is not guaranteed.
- Cycle numbering: accept edge closes cycle 0.
- Fill only: RD occupies cycles 1..LINE_WORDS+1; `done` in cycle LINE_WORDS+2 (6 for LINE_WORDS=4).
- Evict only: WB occupies cycles 1..LINE_WORDS; `done` in cycle LINE_WORDS+1.
- Evict + fill: `done` in cycle 2·LINE_WORDS+2 (10 for LINE_WORDS=4).
- Neither flag: `done` in cycle 1.
- Back-to-back: `req_ready` returns high the cycle after `done`.

## Structure
- Shared package `cache_defs` holds:
  - `LINE_WORDS` and `OFFSET_BITS`=log2(LINE_WORDS)
  - line-address width
  - state encodings, so the cache controller and benches decode the same values.
- Single flat module; the counter and FSM are inline, with no sub-module.

## Test plan
- Reset: hold `rst_n`=0 with `req_valid`=1 -> all outputs at reset values, `req_ready`=1, nothing accepted.
- Fill only: preload BRAM words 0x010..0x013 with 0xA0..0xA3; request `fill_line_addr`=0x04 -> reads at 0x010..0x013 in cycles 1..4, `done` in cycle 6, `fill_data`=0x000000A3_000000A2_000000A1_000000A0.
- Evict + fill, same line 0x04: `victim_data` words 0x11,0x22,0x33,0x44 -> writes in cycles 1..4, then `fill_data` equals `victim_data`, `done` in cycle 10.
- Evict only, `victim_line_addr`=0x3FF -> writes at 0xFFC..0xFFF with no wrap, `mem_re` never high, `done` in cycle 5.
- Busy and no-op requests:
  - Second request pulsed during RD -> ignored; `fill_data` unchanged until the second, held request completes.
  - A request with neither flag set -> `done` in cycle 1.
- Reset at cycle 3 of a writeback -> `mem_we` low immediately, state IDLE, only words 0..1 written.
